// File: rtl/fft_pkg.sv
// fft_pkg: definitions shared by the FFT stage sequencer and the address generator.
//   - seq_state_t : sequencer state encoding (IDLE/RUN/DRAIN/FINISH)
//   - FFT_N_DEF / STAGE_COUNT_BW_DEF / PIPE_LATENCY_DEF : default sizing
//   - drain_len() : effective drain length, max(pipe_latency, 2)
package fft_pkg;

  localparam int FFT_N_DEF          = 10;
  localparam int STAGE_COUNT_BW_DEF = 4;
  localparam int PIPE_LATENCY_DEF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_t;

  // The generator's done is registered and only clears two cycles after run
  // falls, so the gap between stages can never be shorter than 2 cycles.
  function automatic int drain_len(input int pipe_latency);
    return (pipe_latency > 2) ? pipe_latency : 2;
  endfunction

endpackage

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: initiator side of the address generator run/done
// handshake. A start pulse in IDLE walks stageCount through 0..FFT_N-1; each
// stage raises run, waits for done, then holds run low for the drain length so
// the butterfly pipeline empties and the generator's stale done clears.
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   start       in   begin transform (sampled only in IDLE)
//   done        in   stage done from the address generator (used only in RUN)
//   run         out  stage run request
//   stageCount  out  current stage index
//   stageLast   out  busy and stageCount == FFT_N-1
//   busy        out  transform in progress
//   complete    out  one-cycle pulse at transform end
//   cycleCount  out  busy cycles of the last finished transform
//                    (present only when FFT_SEQ_CYCLE_COUNT_EN is defined)
//
// Optional feature macro: FFT_SEQ_CYCLE_COUNT_EN
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int FFT_N          = FFT_N_DEF,
  parameter int STAGE_COUNT_BW = STAGE_COUNT_BW_DEF,
  parameter int PIPE_LATENCY   = PIPE_LATENCY_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      done,
  output logic                      run,
  output logic [STAGE_COUNT_BW-1:0] stageCount,
  output logic                      stageLast,
  output logic                      busy,
  output logic                      complete
`ifdef FFT_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]               cycleCount
`endif
);

  localparam int DRAIN_LEN = drain_len(PIPE_LATENCY);
  localparam int DRAIN_BW  = $clog2(DRAIN_LEN);
  localparam logic [DRAIN_BW-1:0]       DRAIN_LOAD = DRAIN_BW'(DRAIN_LEN - 1);
  localparam logic [STAGE_COUNT_BW-1:0] LAST_STAGE = STAGE_COUNT_BW'(FFT_N - 1);

  seq_state_t                r_state;
  seq_state_t                w_state_next;
  logic [DRAIN_BW-1:0]       r_drain_cnt;
  logic [DRAIN_BW-1:0]       w_drain_next;
  logic [STAGE_COUNT_BW-1:0] r_stage;
  logic [STAGE_COUNT_BW-1:0] w_stage_next;

  always_comb begin
    w_state_next = r_state;
    w_drain_next = r_drain_cnt;
    w_stage_next = r_stage;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_RUN;
          w_stage_next = '0;
        end
      end
      ST_RUN: begin
        if (done) begin
          w_state_next = ST_DRAIN;
          w_drain_next = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) begin
          if (r_stage == LAST_STAGE) begin
            // stageCount is already back at 0 during the complete cycle.
            w_state_next = ST_FINISH;
            w_stage_next = '0;
          end else begin
            w_state_next = ST_RUN;
            w_stage_next = r_stage + STAGE_COUNT_BW'(1);
          end
        end else begin
          w_drain_next = r_drain_cnt - DRAIN_BW'(1);
        end
      end
      ST_FINISH: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
      r_stage     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_next;
      r_stage     <= w_stage_next;
    end
  end

  // All outputs decode directly from registered state, so reset forces them
  // to their idle values on the very next edge.
  assign run        = (r_state == ST_RUN);
  assign busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign complete   = (r_state == ST_FINISH);
  assign stageCount = r_stage;
  assign stageLast  = busy && (r_stage == LAST_STAGE);

`ifdef FFT_SEQ_CYCLE_COUNT_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_cyc_out;

  // The running count has absorbed every busy cycle by the FINISH cycle, so
  // it is published from FINISH and shows up on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc_cnt <= '0;
      r_cyc_out <= '0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_cyc_cnt <= '0;
      end else if (busy && (r_cyc_cnt != 32'hFFFF_FFFF)) begin
        r_cyc_cnt <= r_cyc_cnt + 32'd1;
      end
      if (r_state == ST_FINISH) begin
        r_cyc_out <= r_cyc_cnt;
      end
    end
  end

  assign cycleCount = r_cyc_out;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: two sequencers (PIPE_LATENCY 3 and 0, FFT_N=4) driven
// by shared start/rst, each with its own behavioural address generator. The
// expected outputs come from a timeline model: for cycle t of a transform,
// stage = (t-1)/L and position = (t-1)%L with L = 2^(N-1)+1+D.
module tb_fft_stage_sequencer;

  localparam int N    = 4;
  localparam int BW   = 4;
  localparam int HALF = 1 << (N - 1);
  localparam int NI   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NI-1:0] done_w;
  logic [NI-1:0] run;
  logic [NI-1:0] busy;
  logic [NI-1:0] stage_last;
  logic [NI-1:0] complete;
  logic [BW-1:0] stage_cnt [NI];
  logic [31:0]   cyc_cnt [NI];
  logic [NI-1:0] gen_done;
  logic [NI-1:0] force_done;
  logic [NI-1:0] gen_en;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_inst
      logic gd;
      int   age;
      int   low_cnt;

      fft_stage_sequencer #(
        .FFT_N          (N),
        .STAGE_COUNT_BW (BW),
        .PIPE_LATENCY   ((gi == 0) ? 3 : 0)
      ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .done       (done_w[gi]),
        .run        (run[gi]),
        .stageCount (stage_cnt[gi]),
        .stageLast  (stage_last[gi]),
        .busy       (busy[gi]),
        .complete   (complete[gi])
`ifdef FFT_SEQ_CYCLE_COUNT_EN
        ,
        .cycleCount (cyc_cnt[gi])
`endif
      );

`ifndef FFT_SEQ_CYCLE_COUNT_EN
      assign cyc_cnt[gi] = 32'd0;
`endif

      // Generator: registered done rises 2^(N-1) cycles after run rises and
      // clears two cycles after run falls.
      always @(posedge clk) begin
        if (rst) begin
          gd      <= 1'b0;
          age     <= 0;
          low_cnt <= 0;
        end else if (run[gi]) begin
          age     <= age + 1;
          low_cnt <= 0;
          if (age + 1 >= HALF) gd <= 1'b1;
        end else begin
          age <= 0;
          if (gd) begin
            if (low_cnt == 1) gd <= 1'b0;
            low_cnt <= low_cnt + 1;
          end
        end
      end

      assign gen_done[gi] = gd;
      assign done_w[gi]   = (gen_done[gi] & gen_en[gi]) | force_done[gi];
    end
  endgenerate

  // ---------------- reference model ----------------
  int          t_mod [NI];
  logic [31:0] cc_exp [NI];
  bit          model_on;

  function automatic int drain_of(input int i);
    int pl;
    pl = (i == 0) ? 3 : 0;
    return (pl < 2) ? 2 : pl;
  endfunction

  function automatic int len_of(input int i);
    return HALF + 1 + drain_of(i);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) begin
      int   t;
      int   l;
      int   nl;
      logic e_run, e_busy, e_last, e_comp;
      int   e_stage;
      t  = t_mod[i];
      l  = len_of(i);
      nl = N * l;
      e_run = 0; e_busy = 0; e_last = 0; e_comp = 0; e_stage = 0;
      if (t >= 1 && t <= nl) begin
        e_busy  = 1;
        e_stage = (t - 1) / l;
        e_run   = (((t - 1) % l) <= HALF);
        e_last  = (e_stage == N - 1);
      end else if (t == nl + 1) begin
        e_comp = 1;
      end
      check_val($sformatf("run[%0d]", i), 32'(run[i]), 32'(e_run));
      check_val($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(e_busy));
      check_val($sformatf("stageCount[%0d]", i), 32'(stage_cnt[i]), 32'(e_stage));
      check_val($sformatf("stageLast[%0d]", i), 32'(stage_last[i]), 32'(e_last));
      check_val($sformatf("complete[%0d]", i), 32'(complete[i]), 32'(e_comp));
`ifdef FFT_SEQ_CYCLE_COUNT_EN
      check_val($sformatf("cycleCount[%0d]", i), cyc_cnt[i], cc_exp[i]);
`endif
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, check at
  // the falling edge. frc enables random done forcing where it must be ignored.
  task automatic step(input logic st, input logic rs, input logic frc);
    start = st;
    rst   = rs;
    for (int i = 0; i < NI; i++) begin
      int  t;
      int  l;
      bit  allowed;
      t = t_mod[i];
      l = len_of(i);
      allowed = (t == 0) || (t == N * l + 1) ||
                (t >= 1 && t <= N * l && ((t - 1) % l) > HALF);
      force_done[i] = frc && allowed && ($urandom_range(1, 0) == 1);
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      int nl;
      nl = N * len_of(i);
      if (rs) begin
        t_mod[i]  = 0;
        cc_exp[i] = 32'd0;
      end else if (t_mod[i] == 0) begin
        t_mod[i] = st ? 1 : 0;
      end else if (t_mod[i] == nl + 1) begin
        t_mod[i]  = 0;
        cc_exp[i] = 32'(nl);
      end else begin
        t_mod[i] = t_mod[i] + 1;
      end
    end
    @(negedge clk);
    if (model_on) check_outputs();
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    force_done = '0;
    gen_en     = '1;
    model_on   = 1'b1;
    for (int i = 0; i < NI; i++) begin
      t_mod[i]  = 0;
      cc_exp[i] = 32'd0;
    end

    // reset state
    repeat (3) step(1'b0, 1'b1, 1'b0);

    // single clean transform
    step(1'b1, 1'b0, 1'b0);
    repeat (55) step(1'b0, 1'b0, 1'b0);

    // start held high: back-to-back transforms only via IDLE
    repeat (110) step(1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);

    // reset during stage 1 RUN, then a full transform with forced done noise
    step(1'b1, 1'b0, 1'b0);
    repeat (19) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (55) step(1'b0, 1'b0, 1'b1);

    // randomized start / reset / done noise
    repeat (2000) begin
      step(($urandom_range(11, 0) == 0), ($urandom_range(299, 0) == 0), 1'b1);
    end
    step(1'b0, 1'b1, 1'b0);

    // done held low in RUN: sequencer must wait with run=1 on stage 0
    gen_en   = '0;
    model_on = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    repeat (30) begin
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < NI; i++) begin
        check_val($sformatf("stall_run[%0d]", i), 32'(run[i]), 32'd1);
        check_val($sformatf("stall_busy[%0d]", i), 32'(busy[i]), 32'd1);
        check_val($sformatf("stall_stage[%0d]", i), 32'(stage_cnt[i]), 32'd0);
        check_val($sformatf("stall_complete[%0d]", i), 32'(complete[i]), 32'd0);
      end
    end
    model_on = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    gen_en = '1;
    repeat (2) step(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
